// File: rtl/led_pattern_driver.sv
// Multi-channel LED driver: each channel is OFF, ON, BLINK or PWM.
// Channels are configured through a single-entry valid/ready write port.
// The LED pins are driven straight from registers. The power-on pattern
// stays on the pins until the first write arrives.

// One LED channel. It holds the mode/duty configuration and the output flop.
module led_pattern_chan #(
    parameter int   PWM_BITS = 8,
    parameter logic RST_ON   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                blink_phase,
    output logic                led
);
    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PWM   = 2'd3;

    logic [1:0]          mode_q, mode_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                led_q, led_d;

    // Next config comes from an accepted write. The LED bit is decoded from the
    // config already stored, which gives one cycle of config-to-pin latency.
    always_comb begin
        mode_d = mode_q;
        duty_d = duty_q;
        if (wr_en) begin
            mode_d = wr_mode;
            duty_d = wr_duty;
        end
        case (mode_q)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = blink_phase;
            MODE_PWM:   led_d = (pwm_cnt < duty_q);
            default:    led_d = 1'b0;
        endcase
    end

    // Channel registers. Reset restores the power-on pattern bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= RST_ON ? MODE_ON : MODE_OFF;
            duty_q <= '1;
            led_q  <= RST_ON;
        end else begin
            mode_q <= mode_d;
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign led = led_q;
endmodule

module led_pattern_driver #(
    parameter int                  NUM_LEDS      = 5,
    parameter int                  PWM_BITS      = 8,
    parameter int                  BLINK_TICKS   = 6000000,
    parameter logic [NUM_LEDS-1:0] RESET_PATTERN = 5'b10101,
    localparam int                 CW            = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic [NUM_LEDS-1:0] led
);
    localparam int            BCW        = $clog2(BLINK_TICKS);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_TICKS - 1);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [BCW-1:0]      blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic                arm_q, arm_d;
    logic                ready_q, ready_d;
    logic                accept;

    assign accept    = cfg_valid && ready_q;
    assign cfg_ready = ready_q;

    // Shared timebase: the PWM counter runs free and wraps. The blink counter
    // flips the phase on every wrap. The ready signal comes up two edges after
    // reset is released, with arm_q as the intermediate stage.
    always_comb begin
        pwm_cnt_d     = pwm_cnt_q + 1'b1;
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
        arm_d   = 1'b1;
        ready_d = arm_q;
    end

    // Shared registers. A reset restarts the timebase and closes the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            arm_q         <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            arm_q         <= arm_d;
            ready_q       <= ready_d;
        end
    end

    // One channel instance per LED. A channel number that matches no instance
    // is accepted by the port and then dropped.
    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        logic wr_en;
        assign wr_en = accept && (cfg_chan == CW'(g));

        led_pattern_chan #(
            .PWM_BITS (PWM_BITS),
            .RST_ON   (RESET_PATTERN[g])
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .wr_en       (wr_en),
            .wr_mode     (cfg_mode),
            .wr_duty     (cfg_duty),
            .pwm_cnt     (pwm_cnt_q),
            .blink_phase (blink_phase_q),
            .led         (led[g])
        );
    end
endmodule

// File: tb/tb_led_pattern_driver.sv
// Self-checking bench for led_pattern_driver (5 LEDs, 4-bit PWM, blink every 8).
// The reference model counts edges since reset. It derives the PWM count and
// the blink phase from that edge count.
module tb_led_pattern_driver;
    localparam int         NL = 5;
    localparam int         PB = 4;
    localparam int         BT = 8;
    localparam logic [4:0] RP = 5'b10101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] cfg_chan = '0;
    logic [1:0] cfg_mode = '0;
    logic [3:0] cfg_duty = '0;
    logic [4:0] led;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_mode [NL];
    int m_duty [NL];
    int n = 0;

    led_pattern_driver #(
        .NUM_LEDS      (NL),
        .PWM_BITS      (PB),
        .BLINK_TICKS   (BT),
        .RESET_PATTERN (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_mode  (cfg_mode),
        .cfg_duty  (cfg_duty),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model_led();
        logic [4:0] r;
        for (int i = 0; i < NL; i++) begin
            case (m_mode[i])
                0:       r[i] = 1'b0;
                1:       r[i] = 1'b1;
                2:       r[i] = (((n / BT) % 2) == 0);
                default: r[i] = ((n % (1 << PB)) < m_duty[i]);
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_mode[i] = RP[i] ? 1 : 0;
            m_duty[i] = (1 << PB) - 1;
        end
        n = 0;
    endtask

    // One clock edge. The task works out what the pins and the ready signal
    // should show after the edge, applies the current inputs to the model,
    // then checks the DUT.
    task automatic tick();
        logic [4:0] e_led;
        logic       acc;
        int         ch;
        acc   = !rst && cfg_valid && (n >= 2);
        ch    = int'(cfg_chan);
        e_led = rst ? RP : model_led();
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (acc && ch < NL) begin
                m_mode[ch] = int'(cfg_mode);
                m_duty[ch] = int'(cfg_duty);
            end
            n++;
        end
        chk("led", 32'(led), 32'(e_led));
        chk("cfg_ready", 32'(cfg_ready), 32'((!rst && n >= 2) ? 1 : 0));
    endtask

    task automatic drive(input logic v, input int ch, input int md, input int dt);
        cfg_valid = v;
        cfg_chan  = 3'(ch);
        cfg_mode  = 2'(md);
        cfg_duty  = 4'(dt);
    endtask

    initial begin
        int hi;
        int tg;
        logic prev;
        model_reset();

        // reset, then sit idle
        rst = 1'b1;
        tick();
        tick();
        chk("reset_led", 32'(led), 32'(RP));
        rst = 1'b0;
        tick();
        chk("ready_first_cycle", 32'(cfg_ready), 32'd0);
        for (int i = 0; i < 19; i++) tick();
        chk("idle_led", 32'(led), 32'(RP));
        chk("idle_ready", 32'(cfg_ready), 32'd1);

        // back-to-back writes: chan 1 ON, chan 0 OFF
        drive(1'b1, 1, 1, 0);
        tick();
        drive(1'b1, 0, 0, 0);
        tick();
        chk("b2b_first", 32'(led), 32'h17);
        drive(1'b0, 0, 0, 0);
        tick();
        chk("b2b_second", 32'(led), 32'h16);

        // PWM on chan 2 at duty 0, 5 and 15, counted over three periods each
        for (int k = 0; k < 3; k++) begin
            int d;
            d = (k == 0) ? 0 : ((k == 1) ? 5 : 15);
            drive(1'b1, 2, 3, d);
            tick();
            drive(1'b0, 0, 0, 0);
            hi = 0;
            for (int c = 0; c < 48; c++) begin
                tick();
                if (led[2]) hi++;
            end
            chk($sformatf("pwm_high_duty%0d", d), 32'(hi), 32'(3 * d));
        end

        // chans 3 and 4 to BLINK: they must stay in step and toggle every 8 cycles
        drive(1'b1, 3, 2, 0);
        tick();
        drive(1'b1, 4, 2, 0);
        tick();
        drive(1'b0, 0, 0, 0);
        tick();
        tg   = 0;
        prev = led[3];
        for (int c = 0; c < 32; c++) begin
            tick();
            chk("blink_sync", 32'(led[4]), 32'(led[3]));
            if (led[3] != prev) tg++;
            prev = led[3];
        end
        chk("blink_toggles", 32'(tg), 32'd4);

        // out-of-range channel: the handshake completes and no LED changes
        chk("oor_ready", 32'(cfg_ready), 32'd1);
        drive(1'b1, 7, 1, 0);
        tick();
        drive(1'b0, 0, 0, 0);
        tick();

        // reset pulse mid-blink with PWM active, plus a write that is lost to it
        drive(1'b1, 2, 3, 9);
        tick();
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b1;
        drive(1'b1, 0, 1, 0);
        tick();
        chk("midrst_led", 32'(led), 32'(RP));
        rst = 1'b0;
        drive(1'b0, 0, 0, 0);
        tick();
        tick();
        chk("midrst_ready_back", 32'(cfg_ready), 32'd1);
        drive(1'b1, 3, 2, 0);
        tick();
        drive(1'b0, 0, 0, 0);
        for (int c = 0; c < 20; c++) tick();

        // randomized traffic, including the occasional reset
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(59, 0) == 0);
            drive(1'($urandom_range(1, 0)), int'($urandom_range(7, 0)),
                  int'($urandom_range(3, 0)), int'($urandom_range(15, 0)));
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 0, 0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_pattern_driver.md
# led_pattern_driver

Parametrised multi-channel LED driver for the board LED bank, replacing hard-wired constant LED assignments. Each of NUM_LEDS channels runs in one of four modes: off, on, blink or PWM dimming. Channels are configured at run time through a single-entry valid/ready write port. Outputs come from registers and drive the LED pins directly; a parametrised power-on pattern is shown until the first write.

## Interface
- NUM_LEDS, 5: number of LED channels (1..32).
- PWM_BITS, 8: width of the PWM counter and of each duty value (2..16).
- BLINK_TICKS, 6000000: clock cycles per blink half-period (>=2); 0.5 s at 12 MHz.
- RESET_PATTERN, 5'b10101: NUM_LEDS bits. Bit i=1 puts channel i in ON at reset, 0 puts it in OFF.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  write request.
- cfg_ready  out  1  block can accept a write this cycle.
- cfg_chan  in  CW  target channel; CW = max(1, clog2(NUM_LEDS)).
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=PWM.
- cfg_duty  in  PWM_BITS  duty for PWM mode; stored in every mode.
- led  out  NUM_LEDS  LED drive, bit i = channel i, active high.

## Operation
- Per-channel state: mode[1:0] and duty[PWM_BITS-1:0].
- Shared state:
  - pwm_cnt (PWM_BITS), free-running, +1 every cycle, wraps 2^PWM_BITS-1 -> 0.
  - blink_cnt, counts 0..BLINK_TICKS-1 then wraps to 0.
  - blink_phase (1 bit), toggles in the cycle blink_cnt wraps.
- Write acceptance: a write is accepted on an edge where cfg_valid && cfg_ready. That edge loads mode[cfg_chan] and duty[cfg_chan].
- Out-of-range channel: a write with cfg_chan >= NUM_LEDS is accepted (handshake completes) and discarded. No state changes.
- The port takes at most one write per cycle. There is no back-pressure beyond the reset window.
- Next-state of each LED bit:
  - OFF: 0.
  - ON: 1.
  - BLINK: blink_phase.
  - PWM: (pwm_cnt < duty), unsigned compare.
- All BLINK channels share blink_phase and are therefore synchronised. Writing BLINK does not restart the phase.
- Changing a channel's mode or duty never disturbs pwm_cnt, blink_cnt or other channels.

## Timing
- Reset state, on the edge where rst=1:
  - mode[i] = RESET_PATTERN[i] ? ON : OFF.
  - duty = all ones.
  - pwm_cnt = 0, blink_cnt = 0, blink_phase = 1.
  - led = RESET_PATTERN.
  - cfg_ready = 0.
- cfg_ready stays 0 while rst is high and for the first cycle after rst falls. It goes 1 on the second edge after rst deasserts and then stays 1.
- Asserting rst at any time, including mid-blink or in the cycle of a write, overrides everything. A write coinciding with rst is lost.
- Latency: write accepted at edge E -> config visible at E -> led reflects the new mode at edge E+1. This is one cycle of config-to-pin latency.
- PWM period is 2^PWM_BITS cycles.
  - duty=0: led constantly 0.
  - duty=D: high for exactly D cycles per period, starting at pwm_cnt=0.
  - duty=2^PWM_BITS-1: low for 1 cycle per period.
- Blink period is 2*BLINK_TICKS cycles with a 50% duty cycle. The first toggle to 0 appears on led BLINK_TICKS+1 edges after reset release (one cycle of register delay).
- Writing the same channel on consecutive cycles: the last write wins. Each write still shows its effect for one cycle.

## Test plan
Bench parameters: NUM_LEDS=5, PWM_BITS=4, BLINK_TICKS=8, RESET_PATTERN=5'b10101.

- Reset, then idle 20 cycles:
  - led = 5'b10101 throughout.
  - cfg_ready=0 for the first post-reset cycle, 1 afterwards.
- Write chan 1 mode ON, then chan 0 mode OFF, on back-to-back cycles:
  - led = 5'b10111 one edge after the first write.
  - led = 5'b10110 one edge after the second write.
- Write chan 2 mode PWM duty 0, 5, 15 in turn, sampling 3 periods (48 cycles) each:
  - led[2] high count per 16-cycle period = 0, 5, 15.
- Write chans 3 and 4 mode BLINK:
  - Both bits equal and toggle every 8 cycles (period 16).
  - Other bits are unaffected.
- Write chan 7 (out of range) mode ON: handshake completes, led unchanged.
- Assert rst for 1 cycle mid-blink with PWM active:
  - led returns to 5'b10101 on that edge.
  - Counters restart.
  - cfg_ready drops, then recovers after 1 cycle.
